// File: rtl/seg7_scan_driver_if.sv
// Load/ready handshake and frame strobe between a result producer and the 7-segment scan driver.
// The producer holds the master modport; the driver holds the slave modport.
interface seg7_scan_driver_if;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic        load;
    logic        ready;
    logic        frame_done;

    modport master (
        output data_in,
        output dp_in,
        output load,
        input  ready,
        input  frame_done
    );

    modport slave (
        input  data_in,
        input  dp_in,
        input  load,
        output ready,
        output frame_done
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed 7-segment driver with active-low segments and anodes.
// New values are shadowed and committed only at a frame boundary, so the display never tears.
module seg7_scan_driver #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter bit LZ_BLANK     = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    seg7_scan_driver_if.slave  bus,
    output logic [7:0]         segments,
    output logic [3:0]         anodes
);
    localparam int              CW        = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0]   DIV_MAX   = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0]   BLANK_LIM = CW'(BLANK_CYCLES);

    logic [CW-1:0] div_cnt;
    logic [1:0]    digit_idx;
    logic [15:0]   disp_val;
    logic [3:0]    disp_dp;
    logic [15:0]   pending_val;
    logic [3:0]    pending_dp;
    logic          pending_valid;
    logic          frame_done_r;

    logic          boundary;
    logic [3:0]    cur_nib;
    logic          lz_blank;
    logic          gap_blank;
    logic [7:0]    seg_next;
    logic [3:0]    an_next;

    // Segment pattern for one hex nibble, bits {g,f,e,d,c,b,a}, active-low.
    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign boundary = (digit_idx == 2'd3) && (div_cnt == DIV_MAX);
    assign cur_nib  = disp_val[{digit_idx, 2'b00} +: 4];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        lz_blank = 1'b0;
        if (LZ_BLANK) begin
            case (digit_idx)
                2'd3:    lz_blank = (disp_val[15:12] == 4'h0);
                2'd2:    lz_blank = (disp_val[15:8]  == 8'h00);
                2'd1:    lz_blank = (disp_val[15:4]  == 12'h000);
                default: lz_blank = 1'b0;
            endcase
        end
    end

    // The inter-digit gap lets the previous digit's segments settle before its neighbour lights.
    assign gap_blank = (BLANK_CYCLES > 0) && (div_cnt < BLANK_LIM);

    always_comb begin
        seg_next = 8'hFF;
        an_next  = 4'hF;
        if (!gap_blank && !lz_blank) begin
            an_next  = ~(4'b0001 << digit_idx);
            seg_next = {~disp_dp[digit_idx], hex_decode(cur_nib)};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt   <= '0;
            digit_idx <= 2'd0;
        end else if (div_cnt == DIV_MAX) begin
            div_cnt   <= '0;
            digit_idx <= digit_idx + 2'd1;
        end else begin
            div_cnt   <= div_cnt + 1'b1;
        end
    end

    // A load coinciding with the boundary bypasses the shadow so the freshest value lands this frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            disp_val      <= 16'h0000;
            disp_dp       <= 4'h0;
            pending_val   <= 16'h0000;
            pending_dp    <= 4'h0;
            pending_valid <= 1'b0;
        end else if (boundary) begin
            if (bus.load) begin
                disp_val <= bus.data_in;
                disp_dp  <= bus.dp_in;
            end else if (pending_valid) begin
                disp_val <= pending_val;
                disp_dp  <= pending_dp;
            end
            pending_valid <= 1'b0;
        end else if (bus.load) begin
            pending_val   <= bus.data_in;
            pending_dp    <= bus.dp_in;
            pending_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            segments     <= 8'hFF;
            anodes       <= 4'hF;
            frame_done_r <= 1'b0;
        end else begin
            segments     <= seg_next;
            anodes       <= an_next;
            frame_done_r <= boundary;
        end
    end

    assign bus.ready      = ~pending_valid;
    assign bus.frame_done = frame_done_r;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with REFRESH_DIV=4, BLANK_CYCLES=1, LZ_BLANK=1.
// Each frame is 16 cycles: per digit one dark gap cycle followed by three lit cycles.
module tb_seg7_scan_driver;
    logic       clk;
    logic       rst;
    logic [7:0] segments;
    logic [3:0] anodes;
    int         n_total;
    int         n_pass;

    seg7_scan_driver_if bus ();

    seg7_scan_driver #(
        .REFRESH_DIV  (4),
        .BLANK_CYCLES (1),
        .LZ_BLANK     (1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .segments (segments),
        .anodes   (anodes)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic do_load(input logic [15:0] val, input logic [3:0] dp);
        bus.data_in = val;
        bus.dp_in   = dp;
        bus.load    = 1'b1;
        @(negedge clk);
        bus.load    = 1'b0;
    endtask

    // Advances to the next negedge where frame_done is high, bounded to a few frames.
    task automatic wait_frame_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (bus.frame_done === 1'b1) seen = 1'b1;
        end
        check("frame_done_timeout", 32'(seen), 32'd1);
    endtask

    // Starting on a cycle whose scan state is digit 0 / count 0, checks the next 16 cycles.
    // segs holds expected lit patterns {d3,d2,d1,d0}; lit marks digits that are not blanked.
    task automatic check_frame(input string name, input logic [31:0] segs, input logic [3:0] lit);
        for (int i = 0; i < 16; i++) begin
            int         k;
            logic [3:0] exp_an;
            logic [7:0] exp_seg;
            k = i / 4;
            @(negedge clk);
            if ((i % 4) == 0 || !lit[k]) begin
                exp_an  = 4'hF;
                exp_seg = 8'hFF;
            end else begin
                exp_an  = ~(4'b0001 << k);
                exp_seg = segs[k*8 +: 8];
            end
            check($sformatf("%s_an_c%0d", name, i), 32'(anodes), 32'(exp_an));
            check($sformatf("%s_seg_c%0d", name, i), 32'(segments), 32'(exp_seg));
            check($sformatf("%s_fd_c%0d", name, i), 32'(bus.frame_done), 32'(i == 15));
        end
    endtask

    initial begin
        n_total     = 0;
        n_pass      = 0;
        rst         = 1'b1;
        bus.data_in = 16'h0000;
        bus.dp_in   = 4'h0;
        bus.load    = 1'b0;

        // 1: reset values, then the idle frame shows only digit 0 as "0"
        repeat (2) @(negedge clk);
        check("rst_anodes", 32'(anodes), 32'hF);
        check("rst_segments", 32'(segments), 32'hFF);
        check("rst_ready", 32'(bus.ready), 32'd1);
        check("rst_frame_done", 32'(bus.frame_done), 32'd0);
        rst = 1'b0;
        check_frame("idle", 32'hFFFF_FFC0, 4'b0001);

        // 2: value 9, shadowed until the boundary
        do_load(16'h0009, 4'h0);
        check("t2_ready_low", 32'(bus.ready), 32'd0);
        wait_frame_done();
        check("t2_ready_high", 32'(bus.ready), 32'd1);
        check_frame("t2", 32'hFFFF_FF90, 4'b0001);

        // 3: all four digits with the decimal point on digit 2
        do_load(16'h1234, 4'b0100);
        wait_frame_done();
        check_frame("t3", 32'hF924_B099, 4'b1111);

        // 4: inner zeros stay visible, only the leading zero is blanked
        do_load(16'h0A00, 4'h0);
        wait_frame_done();
        check_frame("t4", 32'hFF88_C0C0, 4'b0111);

        // 5a: a second load before the boundary replaces the first
        do_load(16'h1111, 4'h0);
        @(negedge clk);
        do_load(16'h2222, 4'h0);
        check("t5_ready_low", 32'(bus.ready), 32'd0);
        wait_frame_done();
        check_frame("t5", 32'hA4A4_A4A4, 4'b1111);

        // 5b: load on the boundary cycle itself takes effect at once, ready never drops
        repeat (15) @(negedge clk);
        check("t5b_ready_pre", 32'(bus.ready), 32'd1);
        do_load(16'h3333, 4'b1000);
        check("t5b_ready_post", 32'(bus.ready), 32'd1);
        check("t5b_frame_done", 32'(bus.frame_done), 32'd1);
        check_frame("t5b", 32'h30B0_B0B0, 4'b1111);

        // 6: reset in the middle of digit 2 drops a pending load and restarts the scan
        do_load(16'h5555, 4'hF);
        check("t6_ready_low", 32'(bus.ready), 32'd0);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t6_anodes", 32'(anodes), 32'hF);
        check("t6_segments", 32'(segments), 32'hFF);
        check("t6_ready", 32'(bus.ready), 32'd1);
        check("t6_frame_done", 32'(bus.frame_done), 32'd0);
        rst = 1'b0;
        check_frame("t6_f1", 32'hFFFF_FFC0, 4'b0001);
        check_frame("t6_f2", 32'hFFFF_FFC0, 4'b0001);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
